// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - data-bus memory responder with programmable response latency
module dbus_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        busy,
    output logic        oob
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [63:0]   mem [DEPTH];

    logic [3:0]    cnt;
    logic [AW-1:0] lat_idx;
    logic          lat_inr;
    logic [7:0]    lat_strobe;
    logic [63:0]   lat_data;
    logic [63:0]   hold_data;

    logic          accept;
    logic [63:0]   offset;
    logic          req_inr;
    logic [63:0]   rd_word;
    logic          unused_bits;

    // Incoming request decode: word index from byte offset, range check against the RAM window
    assign accept  = (state == IDLE) && dreq_valid;
    assign offset  = dreq_addr - BASE;
    assign req_inr = (dreq_addr >= BASE) && (dreq_addr < LIMIT);
    assign rd_word = lat_inr ? mem[lat_idx] : 64'h0;

    // Size is carried on the bus but never masks anything; byte offset bits are ignored
    assign unused_bits = ^{dreq_size, offset[63:AW+3], offset[2:0]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: one request outstanding, WAIT is skipped entirely when LATENCY is 0
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (dreq_valid) begin
                    state_nx = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, latency counter, held read data and sticky out-of-range flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 4'd0;
            lat_idx    <= '0;
            lat_inr    <= 1'b0;
            lat_strobe <= 8'h0;
            lat_data   <= 64'h0;
            hold_data  <= 64'h0;
            oob        <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= LAT;
                lat_idx    <= offset[AW+2:3];
                lat_inr    <= req_inr;
                lat_strobe <= dreq_strobe;
                lat_data   <= dreq_data;
                if (!req_inr) begin
                    oob <= 1'b1;
                end
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == RESP) begin
                hold_data <= rd_word;
            end
        end
    end

    // RAM byte-strobe write at the end of the response cycle, so the response carries the pre-write word
    always_ff @(posedge clk) begin
        if (state == RESP && lat_inr) begin
            for (int i = 0; i < 8; i++) begin
                if (lat_strobe[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
                end
            end
        end
    end

    // Outputs: addr_ok is a combinational echo of valid in IDLE, forced low while in reset
    always_comb begin
        dresp_addr_ok = reset && (state == IDLE) && dreq_valid;
        dresp_data_ok = (state == RESP);
        dresp_data    = (state == RESP) ? rd_word : hold_data;
        busy          = (state != IDLE) || dresp_addr_ok;
    end

endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - randomized scoreboard bench for dbus_responder
module tb_dbus_responder;

    localparam int          DEPTH = 64;
    localparam int          LAT   = 2;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dreq_valid = 1'b0;
    logic [63:0] dreq_addr = 64'h0;
    logic [2:0]  dreq_size = 3'd3;
    logic [7:0]  dreq_strobe = 8'h0;
    logic [63:0] dreq_data = 64'h0;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        busy;
    logic        oob;

    dbus_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .BASE    (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .busy          (busy),
        .oob           (oob)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          chk;
        int          cyc;
        bit          oob;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] mdl [DEPTH];
    bit          mdl_oob = 1'b0;
    int          cyc = 0;
    int          last_dok = -100;
    int          ncmp = 0;
    int          nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every data_ok must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset && dresp_data_ok) begin
            last_dok = cyc;
            if (sbq.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL unexpected_data_ok: got data_ok with no request outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("data_ok_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk) check("resp_data", dresp_data, e.data);
                check("oob_flag", 64'(oob), 64'(e.oob));
                check("busy_at_data_ok", 64'(busy), 64'h1);
            end
        end
    end

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
    endfunction

    // Issue one request, wait for acceptance, and record what the memory should answer
    task automatic issue(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d, input bit chk);
        int   n;
        bit   pending;
        bit   inr;
        int   idx;
        exp_t e;
        @(posedge clk);
        #1;
        pending     = (sbq.size() != 0);
        dreq_valid  = 1'b1;
        dreq_addr   = a;
        dreq_strobe = s;
        dreq_data   = d;
        dreq_size   = 3'($urandom_range(0, 3));
        n = 0;
        forever begin
            @(negedge clk);
            if (dresp_addr_ok) break;
            n++;
            if (n > 40) begin
                ncmp++;
                nfail++;
                $display("FAIL accept_timeout: got no addr_ok within 40 cycles for addr %h", a);
                dreq_valid = 1'b0;
                return;
            end
        end
        check("busy_at_accept", 64'(busy), 64'h1);
        if (pending) check("accept_after_data_ok", 64'(cyc), 64'(last_dok + 1));
        inr    = in_range(a);
        idx    = int'((a - BASE) >> 3);
        e.cyc  = cyc + 1 + LAT;
        e.chk  = chk;
        e.data = inr ? mdl[idx] : 64'h0;
        e.oob  = mdl_oob | !inr;
        mdl_oob = e.oob;
        if (inr) begin
            for (int i = 0; i < 8; i++) begin
                if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        dreq_valid  = 1'b0;
        dreq_addr   = {$urandom, $urandom};
        dreq_data   = {$urandom, $urandom};
        dreq_strobe = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                ncmp++;
                nfail++;
                $display("FAIL drain_timeout: got %0d responses still outstanding, expected 0", sbq.size());
                sbq.delete();
            end
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE - 64'd8 * 64'($urandom_range(1, 4));
        if (r == 1) return BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 40));
        return BASE + 64'd8 * 64'($urandom_range(0, DEPTH - 1)) + 64'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [63:0] a;
        int n;

        // Outputs in reset, with valid asserted so addr_ok gating is visible
        dreq_valid = 1'b1;
        #1;
        check("reset_addr_ok", 64'(dresp_addr_ok), 64'h0);
        check("reset_data_ok", 64'(dresp_data_ok), 64'h0);
        check("reset_data", dresp_data, 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_oob", 64'(oob), 64'h0);
        dreq_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) begin
            issue(BASE + 64'(i) * 64'd8, 8'hFF, {$urandom, $urandom}, 1'b0);
        end
        drain();

        // Full write then read back
        issue(64'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b1);
        issue(64'h8000_0010, 8'h00, 64'h0, 1'b1);
        drain();
        check("directed_readback", mdl[2], 64'h1122334455667788);

        // Byte strobe merge into a zeroed word
        issue(BASE, 8'hFF, 64'h0, 1'b1);
        issue(BASE, 8'h0F, 64'hAABB_CCDD_EEFF_0011, 1'b1);
        issue(BASE, 8'h00, 64'h0, 1'b1);
        drain();
        check("strobe_model", mdl[0], 64'h0000_0000_EEFF_0011);

        // Out of range read below the window and write just past it
        issue(64'h7FFF_FFF8, 8'h00, 64'h0, 1'b1);
        issue(BASE + 64'(DEPTH) * 64'd8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        issue(BASE + 64'(DEPTH - 1) * 64'd8, 8'h00, 64'h0, 1'b1);
        drain();
        check("oob_sticky", 64'(oob), 64'h1);

        // Reset during the wait phase of a write: pending write must be abandoned
        a = BASE + 64'd8 * 64'd5;
        @(posedge clk);
        #1;
        dreq_valid  = 1'b1;
        dreq_addr   = a;
        dreq_strobe = 8'hFF;
        dreq_data   = 64'h0BAD_0BAD_0BAD_0BAD;
        n = 0;
        forever begin
            @(negedge clk);
            if (dresp_addr_ok || n > 40) break;
            n++;
        end
        check("reset_test_accept", 64'(dresp_addr_ok), 64'h1);
        @(posedge clk);
        #1;
        dreq_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midop_addr_ok", 64'(dresp_addr_ok), 64'h0);
        check("midop_data_ok", 64'(dresp_data_ok), 64'h0);
        check("midop_data", dresp_data, 64'h0);
        check("midop_busy", 64'(busy), 64'h0);
        check("midop_oob", 64'(oob), 64'h0);
        mdl_oob = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        issue(a, 8'h00, 64'h0, 1'b1);
        drain();

        // Randomized traffic with back-to-back requests and junk on the bus after accept
        for (int k = 0; k < 300; k++) begin
            logic [7:0] s;
            s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            issue(rand_addr(), s, {$urandom, $urandom}, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
